fib_stream: RTL and testbench

// - Parametrised sequence generator: emits every term t0..tn of t(k+2)=t(k)+t(k+1) on a valid/ready stream.
// - Seeds are ports: seeds 1,1 give the Fibonacci sequence (t5=8); seeds 2,1 give the Lucas sequence.
// - Pause gating, stream back-pressure, done pulse; optional overflow-terminated runs.
// - Sits between a command source (start/n/seeds) and a stream sink. Successor to the single-result 10-bit generator.
//

---
 rtl/fib_stream_if.sv | 12 +
 rtl/fib_stream.sv | 112 +++++++++++
 tb/tb_fib_stream.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fib_stream_if.sv
// Valid/ready term stream carried between fib_stream and its sink.
interface fib_stream_if #(
    parameter int unsigned WIDTH = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/fib_stream.sv
// Streams terms t0..tn of t(k+2)=t(k)+t(k+1) from port seeds over a valid/ready stream.
// Define FIB_STREAM_OVF_EN to end a run early (with ovf) when the next computed term overflows.
module fib_stream #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NW    = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pause,
    input  logic             start,
    input  logic [NW-1:0]    n,
    input  logic [WIDTH-1:0] seed0,
    input  logic [WIDTH-1:0] seed1,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    fib_stream_if.master     strm
);
    typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [NW-1:0]    k_q, n_q;
    logic             done_q;
    logic             accept, hs, at_last;

`ifdef FIB_STREAM_OVF_EN
    logic [WIDTH:0] sum;
    logic           bovf_q, ovf_q;
    assign sum     = {1'b0, a_q} + {1'b0, b_q};
    // A pending overflowed b means the beat now presented is the final one.
    assign at_last = (k_q == n_q) || bovf_q;
`else
    logic [WIDTH-1:0] sum;
    assign sum     = a_q + b_q;
    assign at_last = (k_q == n_q);
`endif

    assign accept = (state_q == StIdle) && start && !pause;
    assign hs     = strm.out_valid && strm.out_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StPresent;
            StPresent: begin
                if (hs) begin
                    if (at_last)    state_d = StIdle;
                    else if (pause) state_d = StGap;
                    else            state_d = StPresent;
                end
            end
            StGap:     if (!pause) state_d = StPresent;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            n_q    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q <= seed0;
                b_q <= seed1;
                k_q <= '0;
                n_q <= n;
            end else if (hs) begin
                if (at_last) begin
                    done_q <= 1'b1;
                end else begin
                    a_q <= b_q;
                    b_q <= sum[WIDTH-1:0];
                    k_q <= k_q + NW'(1);
                end
            end
        end
    end

`ifdef FIB_STREAM_OVF_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bovf_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (accept)              bovf_q <= 1'b0;
            else if (hs && !at_last) bovf_q <= sum[WIDTH];
            // Overflow coinciding with the natural last term is not a truncation.
            else if (hs)             ovf_q  <= bovf_q && (k_q != n_q);
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy          = (state_q != StIdle);
    assign done          = done_q;
    assign strm.out_valid = (state_q == StPresent);
    assign strm.out_data  = a_q;
    assign strm.out_last  = (state_q == StPresent) && at_last;
endmodule

// File: tb/tb_fib_stream.sv
// Scoreboard bench for fib_stream: a 16-bit instance for the main scenarios and an
// 8-bit instance for the overflow scenario (behaviour follows FIB_STREAM_OVF_EN).
module tb_fib_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, pause, start16, start8, ready;
    logic [5:0]  n;
    logic [15:0] seed0, seed1;
    logic        busy16, done16, ovf16, busy8, done8, ovf8;

    fib_stream_if #(.WIDTH(16)) s16 ();
    fib_stream_if #(.WIDTH(8))  s8 ();
    assign s16.out_ready = ready;
    assign s8.out_ready  = ready;

    fib_stream #(.WIDTH(16), .NW(6)) dut16 (
        .clk(clk), .resetn(resetn), .pause(pause), .start(start16), .n(n),
        .seed0(seed0), .seed1(seed1), .busy(busy16), .done(done16), .ovf(ovf16),
        .strm(s16.master)
    );
    fib_stream #(.WIDTH(8), .NW(6)) dut8 (
        .clk(clk), .resetn(resetn), .pause(pause), .start(start8), .n(n),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .busy(busy8), .done(done8), .ovf(ovf8),
        .strm(s8.master)
    );

    typedef struct packed {logic [15:0] data; logic last;} beat_t;
    beat_t sb[$];
    logic  exp_ovf;
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model: pushes the expected beats of one run onto the scoreboard.
    function automatic void push_run(int unsigned s0, int unsigned s1, int unsigned nn,
                                     int unsigned w);
        int unsigned mask = (32'd1 << w) - 1;
        int unsigned x = s0 & mask;
        int unsigned y = s1 & mask;
        int unsigned z;
        exp_ovf = 1'b0;
        for (int unsigned k = 0; k <= nn; k++) begin
            beat_t b;
            b.data = x[15:0];
            b.last = (k == nn);
            z = x + y;
`ifdef FIB_STREAM_OVF_EN
            if (!b.last && z > mask && k + 1 < nn) begin
                sb.push_back(b);
                b.data  = y[15:0];
                b.last  = 1'b1;
                exp_ovf = 1'b1;
            end
`endif
            sb.push_back(b);
            if (b.last) break;
            x = y;
            y = z & mask;
        end
    endfunction

    task automatic test_reset();
        n_tests += 6;
        if (busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy16); end
        if (done16 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done16); end
        if (ovf16 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf16); end
        if (s16.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b want 0", s16.out_valid);
        end
        if (s16.out_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_last got %b want 0", s16.out_last);
        end
        if (s16.out_data !== 16'h0) begin
            n_fail++; $display("FAIL reset_data got %h want 0000", s16.out_data);
        end
    endtask

    task automatic test_fib();
        int cyc = 0; int beats = 0; bit fin = 1'b0;
        push_run(1, 1, 5, 16);
        start16 = 1'b1; n = 6'd5; seed0 = 16'd1; seed1 = 16'd1; ready = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        n_tests++;
        if (s16.out_valid !== 1'b1 || busy16 !== 1'b1) begin
            n_fail++; $display("FAIL fib_latency valid=%b busy=%b want 1 1", s16.out_valid, busy16);
        end
        while (!fin && cyc < 40) begin
            if (s16.out_valid && ready && sb.size() > 0) begin
                beat_t e = sb.pop_front();
                n_tests++;
                if (s16.out_data !== e.data || s16.out_last !== e.last || cyc != beats) begin
                    n_fail++;
                    $display("FAIL fib_beat%0d got %0d/%b at cyc %0d want %0d/%b at cyc %0d",
                             beats, s16.out_data, s16.out_last, cyc, e.data, e.last, beats);
                end
                fin = e.last;
                beats++;
            end
            @(negedge clk); cyc++;
        end
        n_tests += 3;
        if (!fin || beats != 6) begin n_fail++; $display("FAIL fib_count got %0d want 6", beats); end
        if (done16 !== 1'b1 || busy16 !== 1'b0 || s16.out_valid !== 1'b0 || ovf16 !== 1'b0) begin
            n_fail++; $display("FAIL fib_done done=%b busy=%b valid=%b ovf=%b want 1 0 0 0",
                               done16, busy16, s16.out_valid, ovf16);
        end
        @(negedge clk);
        if (done16 !== 1'b0) begin n_fail++; $display("FAIL fib_done_pulse got %b want 0", done16); end
    endtask

    task automatic test_backpressure();
        int cyc = 0; int beats = 0; bit fin = 1'b0; bit held = 1'b0; logic [15:0] held_data = '0;
        push_run(2, 1, 4, 16);
        start16 = 1'b1; n = 6'd4; seed0 = 16'd2; seed1 = 16'd1; ready = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        while (!fin && cyc < 40) begin
            if (held) begin
                n_tests++;
                if (s16.out_valid !== 1'b1 || s16.out_data !== held_data) begin
                    n_fail++; $display("FAIL bp_hold got %b/%0d want 1/%0d",
                                       s16.out_valid, s16.out_data, held_data);
                end
            end
            ready = (cyc % 2 == 0);
            held = s16.out_valid && !ready;
            held_data = s16.out_data;
            if (s16.out_valid && ready && sb.size() > 0) begin
                beat_t e = sb.pop_front();
                n_tests++;
                if (s16.out_data !== e.data || s16.out_last !== e.last) begin
                    n_fail++; $display("FAIL bp_beat%0d got %0d/%b want %0d/%b",
                                       beats, s16.out_data, s16.out_last, e.data, e.last);
                end
                fin = e.last;
                beats++;
            end
            @(negedge clk); cyc++;
        end
        ready = 1'b1;
        n_tests += 2;
        if (!fin || beats != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", beats); end
        if (done16 !== 1'b1) begin n_fail++; $display("FAIL bp_done got %b want 1", done16); end
    endtask

    task automatic test_pause();
        int cyc = 0; int beats = 0; int pcnt = 0; bit fin = 1'b0;
        push_run(1, 1, 3, 16);
        start16 = 1'b1; n = 6'd3; seed0 = 16'd1; seed1 = 16'd1; ready = 1'b1; pause = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        while (!fin && cyc < 40) begin
            if (pause) begin
                n_tests++;
                if (s16.out_valid !== 1'b0) begin
                    n_fail++; $display("FAIL pause_gap got valid %b want 0", s16.out_valid);
                end
                if (pcnt == 3) pause = 1'b0;
                else           pcnt++;
            end
            if (s16.out_valid && ready && sb.size() > 0) begin
                beat_t e = sb.pop_front();
                n_tests++;
                if (s16.out_data !== e.data || s16.out_last !== e.last) begin
                    n_fail++; $display("FAIL pause_beat%0d got %0d/%b want %0d/%b",
                                       beats, s16.out_data, s16.out_last, e.data, e.last);
                end
                fin = e.last;
                beats++;
                if (beats == 2) begin pause = 1'b1; pcnt = 1; end
            end
            @(negedge clk); cyc++;
        end
        pause = 1'b0;
        n_tests += 2;
        if (!fin || beats != 4) begin n_fail++; $display("FAIL pause_count got %0d want 4", beats); end
        if (done16 !== 1'b1) begin n_fail++; $display("FAIL pause_done got %b want 1", done16); end
    endtask

    task automatic test_abort();
        int cyc = 0; int beats = 0;
        push_run(1, 1, 10, 16);
        start16 = 1'b1; n = 6'd10; seed0 = 16'd1; seed1 = 16'd1; ready = 1'b1;
        @(negedge clk);
        start16 = 1'b1; n = 6'd3; seed0 = 16'd7; seed1 = 16'd9;
        while (beats < 2 && cyc < 20) begin
            if (s16.out_valid && ready && sb.size() > 0) begin
                beat_t e = sb.pop_front();
                n_tests++;
                if (s16.out_data !== e.data || s16.out_last !== e.last) begin
                    n_fail++; $display("FAIL abort_beat%0d got %0d/%b want %0d/%b",
                                       beats, s16.out_data, s16.out_last, e.data, e.last);
                end
                beats++;
            end
            @(negedge clk); cyc++;
        end
        resetn = 1'b0; start16 = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        sb.delete();
        n_tests += 2;
        if (beats != 2) begin n_fail++; $display("FAIL abort_count got %0d want 2", beats); end
        if (busy16 !== 1'b0 || s16.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle busy=%b valid=%b want 0 0", busy16, s16.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (done16 !== 1'b0 || s16.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL abort_nodone done=%b valid=%b want 0 0", done16, s16.out_valid);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_overflow();
        int cyc = 0; int beats = 0; bit fin = 1'b0; logic [15:0] last_data = '0;
        int want_beats;
`ifdef FIB_STREAM_OVF_EN
        want_beats = 13;
`else
        want_beats = 21;
`endif
        push_run(1, 1, 20, 8);
        start8 = 1'b1; n = 6'd20; seed0 = 16'd1; seed1 = 16'd1; ready = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        while (!fin && cyc < 60) begin
            if (s8.out_valid && ready && sb.size() > 0) begin
                beat_t e = sb.pop_front();
                n_tests++;
                if ({8'h0, s8.out_data} !== e.data || s8.out_last !== e.last) begin
                    n_fail++; $display("FAIL ovf_beat%0d got %0d/%b want %0d/%b",
                                       beats, s8.out_data, s8.out_last, e.data, e.last);
                end
                if (beats == 13) begin
                    n_tests++;
                    if (s8.out_data !== 8'd121) begin
                        n_fail++; $display("FAIL wrap_t13 got %0d want 121", s8.out_data);
                    end
                end
                last_data = {8'h0, s8.out_data};
                fin = e.last;
                beats++;
            end
            @(negedge clk); cyc++;
        end
        n_tests += 2;
        if (!fin || beats != want_beats) begin
            n_fail++; $display("FAIL ovf_count got %0d want %0d", beats, want_beats);
        end
        if (done8 !== 1'b1 || ovf8 !== exp_ovf) begin
            n_fail++; $display("FAIL ovf_flag done=%b ovf=%b want 1 %b", done8, ovf8, exp_ovf);
        end
`ifdef FIB_STREAM_OVF_EN
        n_tests++;
        if (last_data !== 16'd233) begin
            n_fail++; $display("FAIL ovf_last got %0d want 233", last_data);
        end
`endif
    endtask

    task automatic test_single();
        int cyc = 0; int beats = 0; bit fin = 1'b0;
        push_run(16'h1234, 0, 0, 16);
        start16 = 1'b1; n = 6'd0; seed0 = 16'h1234; seed1 = 16'h0; ready = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        while (!fin && cyc < 10) begin
            if (s16.out_valid && ready && sb.size() > 0) begin
                beat_t e = sb.pop_front();
                n_tests++;
                if (s16.out_data !== e.data || s16.out_last !== e.last) begin
                    n_fail++; $display("FAIL single_beat got %h/%b want %h/%b",
                                       s16.out_data, s16.out_last, e.data, e.last);
                end
                fin = e.last;
                beats++;
            end
            @(negedge clk); cyc++;
        end
        n_tests += 2;
        if (!fin || beats != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", beats); end
        if (done16 !== 1'b1 || s16.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_done done=%b valid=%b want 1 0", done16, s16.out_valid);
        end
    endtask

    initial begin
        resetn = 1'b0; pause = 1'b0; start16 = 1'b0; start8 = 1'b0; ready = 1'b0;
        n = '0; seed0 = '0; seed1 = '0;
        repeat (2) @(negedge clk);
        test_reset();
        resetn = 1'b1;
        @(negedge clk);
        test_fib();
        test_backpressure();
        @(negedge clk);
        test_pause();
        @(negedge clk);
        test_abort();
        test_overflow();
        @(negedge clk);
        test_single();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
